// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// vga_scan_controller: VGA timing, upscaled framebuffer scan and test patterns
// Revision 1.0
// ============================================================================
module vga_scan_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = 320,
   parameter int FB_H     = 240,
   parameter int SCALE    = 2,
   parameter int PIX_W    = 2,
   parameter int ADDR_W   = 17,
   parameter int RD_LAT   = 1
) (
   input  logic              clk_25,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic [PIX_W-1:0]  din,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en,
   output logic              hsync,
   output logic              vsync,
   output logic [2:0]        R,
   output logic [2:0]        G,
   output logic [1:0]        B,
   output logic              active,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [HW-1:0]     H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0]     H_WIN  = HW'(FB_W * SCALE);
   localparam logic [HW-1:0]     BAR_W  = HW'(H_ACTIVE / 8);
   localparam logic [VW-1:0]     V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0]     V_WIN  = VW'(FB_H * SCALE);
   localparam logic [SW-1:0]     S_LAST = SW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

   typedef struct packed {
      logic       fs;
      logic       hs;
      logic       vs;
      logic       vis;
      logic       use_fb;
      logic [7:0] pat;
   } stage_t;

   localparam stage_t STAGE_RST = '{fs: 1'b0, hs: 1'b1, vs: 1'b1, vis: 1'b0, use_fb: 1'b0, pat: 8'h00};

   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [VW-1:0]     v_cnt_q, v_cnt_d;
   logic [SW-1:0]     hsub_q, hsub_d, vsub_q, vsub_d;
   logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d;
   logic [1:0]        mode_q, mode_d;
   stage_t            pipe_q [RD_LAT];
   stage_t            pipe_d [RD_LAT];
   logic [7:0]        rgb_q, rgb_d;
   logic              hsync_q, hsync_d, vsync_q, vsync_d;
   logic              active_q, active_d, frame_start_q, frame_start_d;

   logic              h_wrap, in_win, vis, at_origin;
   logic [2:0]        bar_idx, grey3;
   stage_t            stage0, tail;

   // Grey value replicated MSB-first to fill a 3-bit channel
   function automatic logic [2:0] expand3(input logic [PIX_W-1:0] g);
      logic [2:0] e;
      for (int i = 0; i < 3; i++) e[2-i] = g[PIX_W-1-(i % PIX_W)];
      return e;
   endfunction

   always_comb begin
      h_wrap    = (h_cnt_q == H_LAST);
      at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
      in_win    = (h_cnt_q < H_WIN) && (v_cnt_q < V_WIN);
      vis       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      mode_d    = at_origin ? mode : mode_q;
      bar_idx   = 3'(h_cnt_q / BAR_W);

      h_cnt_d    = h_cnt_q + 1'b1;
      v_cnt_d    = v_cnt_q;
      hsub_d     = hsub_q;
      vsub_d     = vsub_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      if (h_wrap) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      // Scan position only moves inside the window so addr holds outside it
      if (h_wrap) begin
         if (v_cnt_d == '0) begin
            row_base_d = '0;
            vsub_d     = '0;
            col_d      = '0;
            hsub_d     = '0;
         end else if (v_cnt_d < V_WIN) begin
            col_d  = '0;
            hsub_d = '0;
            if (vsub_q == S_LAST) begin
               vsub_d     = '0;
               row_base_d = row_base_q + ROW_STEP;
            end else begin
               vsub_d = vsub_q + 1'b1;
            end
         end
      end else if (in_win && (h_cnt_d < H_WIN)) begin
         if (hsub_q == S_LAST) begin
            hsub_d = '0;
            col_d  = col_q + 1'b1;
         end else begin
            hsub_d = hsub_q + 1'b1;
         end
      end

      stage0.fs     = at_origin;
      stage0.hs     = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
      stage0.vs     = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
      stage0.vis    = vis;
      stage0.use_fb = (mode_d == 2'd0) && in_win;
      case (mode_d)
         2'd1:    stage0.pat = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
         2'd2:    stage0.pat = (h_cnt_q[5] ^ v_cnt_q[5]) ? 8'hFF : 8'h00;
         2'd3:    stage0.pat = 8'hFF;
         default: stage0.pat = 8'h00;
      endcase

      pipe_d[0] = stage0;
      for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

      // Tail of the delay line lines up with the BRAM data for the same pixel
      tail  = pipe_q[RD_LAT-1];
      grey3 = expand3(din);
      if (!tail.vis)       rgb_d = 8'h00;
      else if (tail.use_fb) rgb_d = {grey3, grey3, grey3[2:1]};
      else                  rgb_d = tail.pat;
      hsync_d       = tail.hs;
      vsync_d       = tail.vs;
      active_d      = tail.vis;
      frame_start_d = tail.fs;
   end

   always_ff @(posedge clk_25) begin
      if (!reset_n) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsub_q        <= '0;
         vsub_q        <= '0;
         col_q         <= '0;
         row_base_q    <= '0;
         mode_q        <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= STAGE_RST;
         rgb_q         <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         active_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsub_q        <= hsub_d;
         vsub_q        <= vsub_d;
         col_q         <= col_d;
         row_base_q    <= row_base_d;
         mode_q        <= mode_d;
         pipe_q        <= pipe_d;
         rgb_q         <= rgb_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Read strobe is suppressed while reset is held so the port stays idle
   assign addr        = row_base_q + col_q;
   assign rd_en       = in_win & reset_n;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign R           = rgb_q[7:5];
   assign G           = rgb_q[4:2];
   assign B           = rgb_q[1:0];
   assign active      = active_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_controller.sv
`default_nettype none
// tb_vga_scan_controller: scoreboard bench on a reduced 80x22 timing with a 16x6 framebuffer.
module tb_vga_scan_controller;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 16, VF = 2, VS = 2, VB = 2;
   localparam int HT = 80, VT = 22, FRAME = 1760;
   localparam int FBW = 16, FBH = 6, SC = 2, LAT = 2, PIPE = LAT + 1;
   localparam int REL = 9;
   localparam int RS = REL + 4 * FRAME + 10 * HT + 5;
   localparam int TOTAL = RS + 3 + FRAME + 200;
   localparam logic [11:0] PIN_RST = 12'hC00;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] mode;
   logic [1:0] din;
   logic [7:0] addr;
   logic       rd_en, hsync, vsync, active, frame_start;
   logic [2:0] red, green;
   logic [1:0] blue;

   always #5 clk = ~clk;

   vga_scan_controller #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .FB_W(FBW), .FB_H(FBH), .SCALE(SC), .PIX_W(2), .ADDR_W(8), .RD_LAT(LAT)
   ) dut (
      .clk_25(clk), .reset_n(reset_n), .mode(mode), .din(din),
      .addr(addr), .rd_en(rd_en), .hsync(hsync), .vsync(vsync),
      .R(red), .G(green), .B(blue), .active(active), .frame_start(frame_start)
   );

   // Two-cycle BRAM whose contents are addr[1:0]
   logic [1:0] b1 = 2'd0, b2 = 2'd0;
   always @(posedge clk) begin
      if (rd_en) b1 <= addr[1:0];
      b2 <= b1;
   end
   assign din = b2;

   int stamp = -1;
   always @(posedge clk) stamp <= stamp + 1;

   typedef struct { int due; logic [11:0] val; } pin_t;
   typedef struct { int due; logic [8:0] val; } rd_t;
   pin_t qp[$];
   rd_t  qr[$];

   int checks = 0, failures = 0;
   bit done = 0;

   int hs_f1 = -1, hs_f2 = -1, hs_r1 = -1, vs_f1 = -1, vs_f2 = -1, vs_r1 = -1;
   int fs1 = -1, fs2 = -1, fs_rst = -1, last_fb = -1;
   int bar0 = -1, bar8 = -1, bar48 = -1, chk32 = -1, border32 = -1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Monitor: pops expectations when their due cycle reaches the pins
   initial begin
      pin_t ep;
      rd_t  er;
      logic hs_p, vs_p;
      hs_p = 1'b1;
      vs_p = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (qr.size() > 0 && qr[0].due == stamp) begin
            er = qr.pop_front();
            chk($sformatf("rdport@%0d", stamp), {23'd0, rd_en, addr}, {23'd0, er.val});
         end
         if (qp.size() > 0 && qp[0].due == stamp) begin
            ep = qp.pop_front();
            chk($sformatf("pins@%0d", stamp),
                {20'd0, hsync, vsync, active, frame_start, red, green, blue}, {20'd0, ep.val});
         end
         if (hs_p === 1'b1 && hsync === 1'b0) begin
            if (hs_f1 < 0) hs_f1 = stamp; else if (hs_f2 < 0) hs_f2 = stamp;
         end
         if (hs_p === 1'b0 && hsync === 1'b1 && hs_f1 >= 0 && hs_r1 < 0) hs_r1 = stamp;
         if (vs_p === 1'b1 && vsync === 1'b0) begin
            if (vs_f1 < 0) vs_f1 = stamp; else if (vs_f2 < 0) vs_f2 = stamp;
         end
         if (vs_p === 1'b0 && vsync === 1'b1 && vs_f1 >= 0 && vs_r1 < 0) vs_r1 = stamp;
         hs_p = hsync;
         vs_p = vsync;
         if (frame_start === 1'b1) begin
            if (fs1 < 0) fs1 = stamp; else if (fs2 < 0) fs2 = stamp;
         end
         if (rd_en === 1'b1 && stamp < REL + FRAME) last_fb = int'(addr);
         if (stamp == REL + PIPE + 32)             border32 = int'({red, green, blue});
         if (stamp == REL + FRAME + PIPE)          bar0 = int'({red, green, blue});
         if (stamp == REL + FRAME + PIPE + 8)      bar8 = int'({red, green, blue});
         if (stamp == REL + FRAME + PIPE + 48)     bar48 = int'({red, green, blue});
         if (stamp == REL + 2 * FRAME + PIPE + 32) chk32 = int'({red, green, blue});
         if (stamp == RS + 3 + PIPE)               fs_rst = int'(frame_start);
      end
   end

   // Stimulus and reference model
   initial begin
      int x, y, last_a, fmode, a, idx;
      logic win, vis, hs_e, vs_e, fs_e;
      logic [7:0] rgb;
      logic [1:0] g;
      x = 0; y = 0; last_a = 0; fmode = 0;
      reset_n = 1'b0;
      mode = 2'd0;
      for (int s = 0; s < TOTAL; s++) begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            x = 0; y = 0; last_a = 0;
            foreach (qp[i]) if (qp[i].due >= stamp) qp[i].val = PIN_RST;
         end else begin
            x++;
            if (x == HT) begin
               x = 0;
               y = (y == VT - 1) ? 0 : y + 1;
            end
         end

         if (stamp == REL) reset_n = 1'b1;
         if (stamp == RS) reset_n = 1'b0;
         if (stamp == RS + 3) reset_n = 1'b1;
         for (int k = 0; k < 4; k++)
            if (stamp == REL + 500 + k * FRAME) mode = (k == 3) ? 2'd0 : 2'(k + 1);

         if (x == 0 && y == 0) fmode = int'(mode);
         win = (x < FBW * SC) && (y < FBH * SC);
         vis = (x < HA) && (y < VA);
         a = (y / SC) * FBW + x / SC;
         if (win) last_a = a;
         qr.push_back('{due: stamp, val: {win & reset_n, 8'(last_a)}});

         hs_e = !(x >= HA + HF && x < HA + HF + HS);
         vs_e = !(y >= VA + VF && y < VA + VF + VS);
         fs_e = (x == 0 && y == 0);
         idx = x / (HA / 8);
         g = 2'(a);
         if (!vis) rgb = 8'h00;
         else if (fmode == 0) rgb = win ? {g[1], g[0], g[1], g[1], g[0], g[1], g[1], g[0]} : 8'h00;
         else if (fmode == 1) rgb = {(idx & 4) != 0 ? 3'd7 : 3'd0, (idx & 2) != 0 ? 3'd7 : 3'd0,
                                     (idx & 1) != 0 ? 2'd3 : 2'd0};
         else if (fmode == 2) rgb = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 8'hFF : 8'h00;
         else rgb = 8'hFF;
         qp.push_back('{due: stamp + PIPE, val: {hs_e, vs_e, vis, fs_e, rgb}});
      end
      repeat (PIPE + 2) @(posedge clk);
      @(negedge clk);
      done = 1;
      @(posedge clk);

      chk("queues_drained", 32'(qp.size() + qr.size()), 32'd0);
      chk("first_hsync_low", hs_f1, 80);
      chk("hsync_period", hs_f2 - hs_f1, 80);
      chk("hsync_low_width", hs_r1 - hs_f1, 8);
      chk("first_vsync_low", vs_f1, 1452);
      chk("vsync_period", vs_f2 - vs_f1, 1760);
      chk("vsync_low_width", vs_r1 - vs_f1, 160);
      chk("first_frame_start", fs1, 12);
      chk("frame_start_period", fs2 - fs1, 1760);
      chk("last_fb_addr", last_fb, 95);
      chk("border_x32", border32, 32'h00);
      chk("bars_x0", bar0, 32'h00);
      chk("bars_x8", bar8, 32'h03);
      chk("bars_x48", bar48, 32'hFC);
      chk("checker_x32", chk32, 32'hFF);
      chk("frame_start_after_reset", fs_rst, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
